// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared FSM encoding and constants for the bcd conversion scheduler
package bcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STORE  = 3'd4
  } state_t;

  localparam int MAXV_DEF = 9999;
  localparam int DIGW     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin select: first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - shares one bin2bcd converter between NREQ channels with clamp and timeout
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int DW      = 14,
  parameter int TIMEOUT = 64,
  parameter int MAXV    = MAXV_DEF
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ*16-1:0]   res_bcd,
  output logic [NREQ-1:0]      res_valid,
  output logic [NREQ-1:0]      res_ovf,
  output logic [NREQ-1:0]      res_err,
  output logic [DW-1:0]        cnv_data,
  output logic                 cnv_enable,
  input  logic [DIGW-1:0]      cnv_tho,
  input  logic [DIGW-1:0]      cnv_hun,
  input  logic [DIGW-1:0]      cnv_ten,
  input  logic [DIGW-1:0]      cnv_uni,
  input  logic                 cnv_done,
  output logic                 busy
);

  localparam int              PW       = $clog2(NREQ);
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0]   MAXV_W   = DW'(MAXV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(NREQ - 1);

  state_t            state, state_n;
  logic [PW-1:0]     ptr, gidx, arb_idx;
  logic [NREQ-1:0]   arb_gnt;
  logic              arb_any;
  logic [CW-1:0]     cnt;
  logic              done_q, ovf_q;
  logic              done_rise, cnt_expired;
  logic [DW-1:0]     op;
  logic              op_ovf;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign op          = req_data[int'(arb_idx)*DW +: DW];
  assign op_ovf      = op > MAXV_W;
  // only a fresh edge completes; a done level left from the last conversion is ignored
  assign done_rise   = cnv_done & ~done_q;
  assign cnt_expired = cnt == CNT_LAST;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (arb_any) state_n = ST_GRANT;
      ST_GRANT:  state_n = ST_LAUNCH;
      ST_LAUNCH: state_n = ST_WAIT;
      ST_WAIT: begin
        if (done_rise)        state_n = ST_STORE;
        else if (cnt_expired) state_n = ST_IDLE;
      end
      ST_STORE:  state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // grant bookkeeping is registered on the edge entering GRANT so ack is visible there
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      gidx       <= '0;
      cnt        <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ack        <= '0;
      res_bcd    <= '0;
      res_valid  <= '0;
      res_ovf    <= '0;
      res_err    <= '0;
      cnv_data   <= '0;
      cnv_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack        <= '0;
      cnv_enable <= (state_n == ST_LAUNCH);
      busy       <= (state_n != ST_IDLE);
      done_q     <= cnv_done;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            ack                <= arb_gnt;
            gidx               <= arb_idx;
            cnv_data           <= op_ovf ? MAXV_W : op;
            ovf_q              <= op_ovf;
            res_valid[arb_idx] <= 1'b0;
            res_err[arb_idx]   <= 1'b0;
            ptr                <= (arb_idx == PTR_LAST) ? '0 : arb_idx + 1'b1;
          end
        end
        ST_LAUNCH: cnt <= '0;
        ST_WAIT: begin
          if (!done_rise) begin
            if (cnt_expired) begin
              res_err[gidx]   <= 1'b1;
              res_valid[gidx] <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_STORE: begin
          res_bcd[int'(gidx)*16 +: 16] <= {cnv_tho, cnv_hun, cnv_ten, cnv_uni};
          res_valid[gidx]              <= 1'b1;
          res_ovf[gidx]                <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - scoreboard bench for bcd_conv_sched with a behavioural converter model
module tb_bcd_conv_sched;

  localparam int N  = 3;
  localparam int DW = 14;

  logic              clkin;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      ack;
  logic [N*16-1:0]   res_bcd;
  logic [N-1:0]      res_valid, res_ovf, res_err;
  logic [DW-1:0]     cnv_data;
  logic              cnv_enable;
  logic [3:0]        cnv_tho, cnv_hun, cnv_ten, cnv_uni;
  logic              cnv_done;
  logic              busy;

  bcd_conv_sched #(.NREQ(N), .DW(DW), .TIMEOUT(64), .MAXV(9999)) dut (
    .clkin(clkin), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .res_bcd(res_bcd), .res_valid(res_valid), .res_ovf(res_ovf), .res_err(res_err),
    .cnv_data(cnv_data), .cnv_enable(cnv_enable),
    .cnv_tho(cnv_tho), .cnv_hun(cnv_hun), .cnv_ten(cnv_ten), .cnv_uni(cnv_uni),
    .cnv_done(cnv_done), .busy(busy)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  typedef struct { int ch; logic [15:0] bcd; logic ovf; logic err; } res_t;
  typedef struct { int ch; int op; } gnt_t;

  res_t        rq[$];
  gnt_t        gq[$];
  int          tests = 0;
  int          fails = 0;
  int          conv_mode = 0;
  int          mptr = 0;
  logic [15:0] last_bcd [N];
  logic [N-1:0] last_ovf;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // converter model: mode 0 normal, 1 holds stale done a few cycles, 2 never completes
  initial begin
    int d, lat;
    cnv_done = 1'b0;
    {cnv_tho, cnv_hun, cnv_ten, cnv_uni} = 16'h0;
    forever begin
      @(negedge clkin);
      if (!reset) begin
        cnv_done = 1'b0;
        {cnv_tho, cnv_hun, cnv_ten, cnv_uni} = 16'h0;
      end else if (cnv_enable) begin
        d   = int'(cnv_data);
        lat = $urandom_range(1, 8);
        if (conv_mode == 1) repeat (3) @(negedge clkin);
        cnv_done = 1'b0;
        if (conv_mode != 2) begin
          repeat (lat) @(negedge clkin);
          {cnv_tho, cnv_hun, cnv_ten, cnv_uni} = to_bcd(d);
          cnv_done = 1'b1;
        end
      end
    end
  end

  // monitor: compares grants and results against the scoreboard queues
  initial begin
    logic [N-1:0] prev_valid;
    logic         prev_en, en_exp;
    gnt_t         ge;
    res_t         re;
    prev_valid = '0;
    prev_en    = 1'b0;
    en_exp     = 1'b0;
    forever begin
      @(negedge clkin);
      if (!reset) begin
        prev_valid = '0;
        prev_en    = 1'b0;
        en_exp     = 1'b0;
      end else begin
        if (en_exp) check("enable_after_ack", longint'(cnv_enable), 1);
        en_exp = 1'b0;
        if (cnv_enable) check("enable_width", longint'(prev_en), 0);
        prev_en = cnv_enable;
        if (ack != '0) begin
          if (gq.size() == 0) check("ack_unexpected", longint'(ack), 0);
          else begin
            ge = gq.pop_front();
            check("ack_channel", longint'(ack), longint'(1) << ge.ch);
            check("cnv_data", longint'(cnv_data), longint'(ge.op));
          end
          en_exp = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
          if (res_valid[i] && !prev_valid[i]) begin
            if (rq.size() == 0) check("res_unexpected", longint'(i), -1);
            else begin
              re = rq.pop_front();
              check("res_channel", longint'(i), longint'(re.ch));
              check("res_bcd", longint'(res_bcd[i*16 +: 16]), longint'(re.bcd));
              check("res_ovf", longint'(res_ovf[i]), longint'(re.ovf));
              check("res_err", longint'(res_err[i]), longint'(re.err));
            end
          end
        end
        prev_valid = res_valid;
      end
    end
  end

  task automatic run_batch(input logic [N-1:0] mask, input int d0, input int d1, input int d2,
                           input int mode_i);
    int           ops [N];
    logic [N-1:0] pend;
    int           g, c, cl, cyc;
    ops[0] = d0; ops[1] = d1; ops[2] = d2;
    conv_mode = mode_i;
    pend = mask;
    while (pend != '0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        c = (mptr + k) % N;
        if (g < 0 && pend[c]) g = c;
      end
      cl = (ops[g] > 9999) ? 9999 : ops[g];
      gq.push_back('{g, cl});
      if (mode_i == 2) rq.push_back('{g, last_bcd[g], last_ovf[g], 1'b1});
      else begin
        last_bcd[g] = to_bcd(cl);
        last_ovf[g] = (ops[g] > 9999);
        rq.push_back('{g, last_bcd[g], last_ovf[g], 1'b0});
      end
      pend[g] = 1'b0;
      mptr    = (g + 1) % N;
    end
    @(negedge clkin);
    req_data = {DW'(d2), DW'(d1), DW'(d0)};
    req      = mask;
    cyc      = 0;
    while ((req != '0 || rq.size() != 0 || busy) && cyc < 2000) begin
      @(negedge clkin);
      req = req & ~ack;
      cyc++;
    end
    check("batch_bound", longint'(cyc >= 2000), 0);
    req = '0;
    @(negedge clkin);
  endtask

  function automatic int rand_op();
    case ($urandom_range(0, 3))
      0:       return 9999;
      1:       return $urandom_range(10000, 16383);
      2:       return $urandom_range(0, 9999);
      default: return $urandom_range(0, 99);
    endcase
  endfunction

  initial begin
    int cyc, md;
    reset    = 1'b0;
    req      = '0;
    req_data = '0;
    last_ovf = '0;
    for (int i = 0; i < N; i++) last_bcd[i] = 16'h0;
    repeat (3) @(negedge clkin);
    check("rst_busy", longint'(busy), 0);
    check("rst_res_valid", longint'(res_valid), 0);
    check("rst_ack", longint'(ack), 0);
    check("rst_enable", longint'(cnv_enable), 0);
    reset = 1'b1;
    @(negedge clkin);

    run_batch(3'b001, 9999, 0, 0, 0);
    run_batch(3'b111, 3421, 0, 1234, 0);
    run_batch(3'b111, 1, 2, 3, 0);
    run_batch(3'b010, 0, 12000, 0, 0);
    run_batch(3'b001, 7777, 0, 0, 0);
    run_batch(3'b010, 0, 5, 0, 1);
    run_batch(3'b100, 0, 0, 555, 2);
    run_batch(3'b100, 0, 0, 321, 0);

    for (int t = 0; t < 25; t++) begin
      md = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      run_batch(N'($urandom_range(1, 7)), rand_op(), rand_op(), rand_op(), md);
    end

    // reset mid-WAIT with a converter that never answers
    run_batch(3'b001, 1111, 0, 0, 0);
    conv_mode = 2;
    gq.push_back('{0, 7000});
    req_data = {DW'(0), DW'(0), DW'(7000)};
    req      = 3'b001;
    cyc      = 0;
    while (!cnv_enable && cyc < 100) begin
      @(negedge clkin);
      req = req & ~ack;
      cyc++;
    end
    check("reset_launch_bound", longint'(cyc >= 100), 0);
    repeat (5) @(negedge clkin);
    #2 reset = 1'b0;
    #1;
    check("arst_ack", longint'(ack), 0);
    check("arst_res_bcd", longint'(res_bcd), 0);
    check("arst_res_valid", longint'(res_valid), 0);
    check("arst_res_ovf", longint'(res_ovf), 0);
    check("arst_res_err", longint'(res_err), 0);
    check("arst_cnv_data", longint'(cnv_data), 0);
    check("arst_enable", longint'(cnv_enable), 0);
    check("arst_busy", longint'(busy), 0);
    rq.delete();
    gq.delete();
    req  = '0;
    mptr = 0;
    last_ovf = '0;
    for (int i = 0; i < N; i++) last_bcd[i] = 16'h0;
    repeat (2) @(negedge clkin);
    reset = 1'b1;
    @(negedge clkin);
    check("post_rst_busy", longint'(busy), 0);
    run_batch(3'b101, 42, 0, 77, 0);

    repeat (3) @(negedge clkin);
    check("queue_drained", longint'(rq.size() + gq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
